// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters.
// One operation is in flight at a time: IDLE (grant/accept) -> EXEC (ALU
// computes) -> CAPT (result captured) -> RESP (held until consumed).
module alu_rr_sched #(
   parameter int  NUM_REQ = 4,
   parameter int  DATA_W  = 32,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*3-1:0]      req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [2:0]                alu_opcode,
   input  logic [DATA_W-1:0]         alu_result,
   input  logic                      alu_error,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDW-1:0]            rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t              state_q,      state_d;
   logic [IDW-1:0]      last_grant_q, last_grant_d;
   logic [IDW-1:0]      cur_id_q,     cur_id_d;
   logic [DATA_W-1:0]   alu_a_q,      alu_a_d;
   logic [DATA_W-1:0]   alu_b_q,      alu_b_d;
   logic [2:0]          alu_opcode_q, alu_opcode_d;
   logic [IDW-1:0]      rsp_id_q,     rsp_id_d;
   logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
   logic                rsp_error_q,  rsp_error_d;

   logic                grant_vld;
   logic [IDW-1:0]      grant_idx;

   // Round-robin pick: first valid above last_grant, else first valid at or below it.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid[i] && (i > int'(last_grant_q))) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid[i] && (i <= int'(last_grant_q))) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(i);
         end
      end
   end

   // Next-state, datapath loads and the one-hot accept, all from the current state.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_opcode_d = alu_opcode_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      req_ready    = '0;
      unique case (state_q)
         IDLE: begin
            // Accept is withheld while reset is asserted so no requester sees a phantom grant.
            if (grant_vld && !rst) begin
               req_ready[grant_idx] = 1'b1;
               alu_a_d      = req_a[int'(grant_idx)*DATA_W +: DATA_W];
               alu_b_d      = req_b[int'(grant_idx)*DATA_W +: DATA_W];
               alu_opcode_d = req_op[int'(grant_idx)*3 +: 3];
               cur_id_d     = grant_idx;
               last_grant_d = grant_idx;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            state_d = CAPT;
         end
         CAPT: begin
            rsp_result_d = alu_result;
            rsp_error_d  = alu_error;
            rsp_id_d     = cur_id_q;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   // NOTE: reset is asynchronous so rsp_valid (decoded from state) falls without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NUM_REQ - 1);
         cur_id_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= 3'b000;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: a stand-in registered ALU, a
// transaction-level reference model that predicts grants and responses, and a
// scoreboard monitor that compares every response the DUT presents.
module tb_alu_rr_sched;

   localparam int N = 4;
   localparam int W = 32;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -MAXV - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N*3-1:0] req_op = '0;
   logic [W-1:0]   alu_a, alu_b;
   logic [2:0]     alu_opcode;
   logic [W-1:0]   alu_result = '0;
   logic           alu_error = 1'b0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_result;
   logic           rsp_error;

   alu_rr_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_error(alu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in ALU: bit-level overflow from operand/result sign bits, registered.
   logic [W-1:0] alu_nxt_res;
   logic         alu_nxt_err;
   always_comb begin
      alu_nxt_res = '0;
      alu_nxt_err = 1'b1;
      case (alu_opcode)
         3'b000: begin
            alu_nxt_res = alu_a + alu_b;
            alu_nxt_err = (alu_a[W-1] == alu_b[W-1]) && (alu_nxt_res[W-1] != alu_a[W-1]);
         end
         3'b001: begin
            alu_nxt_res = alu_a - alu_b;
            alu_nxt_err = (alu_a[W-1] != alu_b[W-1]) && (alu_nxt_res[W-1] != alu_a[W-1]);
         end
         3'b010: begin alu_nxt_res = alu_a & alu_b; alu_nxt_err = 1'b0; end
         3'b011: begin alu_nxt_res = alu_a | alu_b; alu_nxt_err = 1'b0; end
         3'b100: begin alu_nxt_res = alu_a ^ alu_b; alu_nxt_err = 1'b0; end
         default: begin alu_nxt_res = '0; alu_nxt_err = 1'b1; end
      endcase
   end
   always @(posedge clk) begin
      alu_result <= alu_nxt_res;
      alu_error  <= alu_nxt_err;
   end

   // ---------------- checking infrastructure ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU in plain signed arithmetic.
   function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                   output logic [31:0] r, output logic e);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      e  = 1'b1;
      case (op)
         3'd0: begin s = sa + sb; r = a + b; e = (s > MAXV) || (s < MINV); end
         3'd1: begin s = sa - sb; r = a - b; e = (s > MAXV) || (s < MINV); end
         3'd2: begin r = a & b; e = 1'b0; end
         3'd3: begin r = a | b; e = 1'b0; end
         3'd4: begin r = a ^ b; e = 1'b0; end
         default: begin r = '0; e = 1'b1; end
      endcase
   endfunction

   typedef struct {
      logic [1:0]  id;
      logic [31:0] res;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];

   // Reference model state (transaction level: busy flag + cycle of accept).
   bit           m_busy = 1'b0;
   int           m_last = N - 1;
   int           m_acc_cyc = 0;
   logic [W-1:0] m_alu_a = '0, m_alu_b = '0;
   logic [2:0]   m_alu_op = '0;
   logic [N-1:0] acc_mask = '0;

   // Reference model: predicts accepts, ALU drive, and response timing every cycle.
   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      int           g;
      bit           exp_rv;
      rsp_t         e;
      if (rst) begin
         check("reset req_ready", req_ready, 0);
         check("reset alu_a", alu_a, 0);
         check("reset alu_b", alu_b, 0);
         check("reset alu_opcode", alu_opcode, 0);
         check("reset rsp_valid", rsp_valid, 0);
         check("reset rsp_id", rsp_id, 0);
         check("reset rsp_result", rsp_result, 0);
         check("reset rsp_error", rsp_error, 0);
         m_busy   = 1'b0;
         m_last   = N - 1;
         m_alu_a  = '0;
         m_alu_b  = '0;
         m_alu_op = '0;
         acc_mask = '0;
         exp_q.delete();
      end else begin
         exp_ready = '0;
         g = -1;
         if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
               if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         check("req_ready", req_ready, exp_ready);
         check("alu_a", alu_a, m_alu_a);
         check("alu_b", alu_b, m_alu_b);
         check("alu_opcode", alu_opcode, m_alu_op);
         exp_rv = m_busy && (cyc - m_acc_cyc >= 3);
         check("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv && rsp_ready) m_busy = 1'b0;
         acc_mask = exp_ready;
         if (g >= 0) begin
            m_alu_a  = req_a[g*W +: W];
            m_alu_b  = req_b[g*W +: W];
            m_alu_op = req_op[g*3 +: 3];
            e.id = 2'(g);
            ref_alu(m_alu_a, m_alu_b, m_alu_op, e.res, e.err);
            exp_q.push_back(e);
            m_last    = g;
            m_busy    = 1'b1;
            m_acc_cyc = cyc;
         end
      end
   end

   // Monitor: logs DUT accepts and scoreboards every presented response.
   int dut_acc_cyc[$];
   int dut_acc_id[$];
   int id_log[$];
   always @(negedge clk) begin
      rsp_t e;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) begin
               dut_acc_cyc.push_back(cyc);
               dut_acc_id.push_back(i);
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected response", 1, 0);
            end else begin
               e = exp_q[0];
               check("rsp_id", rsp_id, e.id);
               check("rsp_result", rsp_result, e.res);
               check("rsp_error", rsp_error, e.err);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  id_log.push_back(int'(rsp_id));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int repost_left = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_mask[i]) begin
            if (repost_left > 0) repost_left--;
            else req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic post(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_op[id*3 +: 3] = op;
      req_valid[id] = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((req_valid != 0 || m_busy || exp_q.size() != 0) && n < 400) begin
         tick();
         n++;
      end
      check({name, " completes"}, (n < 400), 1);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic clear_logs();
      dut_acc_cyc.delete();
      dut_acc_id.delete();
      id_log.delete();
   endtask

   initial begin
      int n;
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      tick();

      // Single ADD from requester 2
      clear_logs();
      post(2, 32'd5, 32'd7, OP_ADD);
      drain("single add");
      check("single add rsp count", id_log.size(), 1);
      if (id_log.size() > 0) check("single add id", id_log[0], 2);

      // Signed overflow on ADD and SUB
      post(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
      drain("overflow add");
      post(0, 32'h8000_0000, 32'd1, OP_SUB);
      drain("overflow sub");

      // Round-robin under constant all-valid load
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear_logs();
      for (int i = 0; i < N; i++) post(i, 32'(i), $urandom, OP_XOR);
      repost_left = 2;
      drain("round robin");
      check("rr accept count", dut_acc_id.size(), 6);
      for (int k = 0; k < id_log.size() && k < 6; k++) check("rr rsp_id order", id_log[k], exp_seq[k]);
      for (int k = 1; k < dut_acc_cyc.size(); k++)
         check("rr accept spacing", dut_acc_cyc[k] - dut_acc_cyc[k-1], 4);

      // Back-pressure with requesters 1 and 3 pending
      clear_logs();
      rsp_ready = 1'b0;
      post(1, $urandom, $urandom, OP_SUB);
      post(3, $urandom, $urandom, OP_ADD);
      repeat (14) tick();
      check("bp single accept while stalled", dut_acc_id.size(), 1);
      rsp_ready = 1'b1;
      drain("back-pressure");
      check("bp accept count", dut_acc_id.size(), 2);
      if (dut_acc_id.size() == 2) begin
         check("bp first grant", dut_acc_id[0], 3);
         check("bp next grant", dut_acc_id[1], 1);
      end

      // Reserved opcode then AND on the same operands
      post(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110);
      drain("reserved op");
      post(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_AND);
      drain("and after reserved");

      // Reset during EXEC
      for (int i = 0; i < N; i++) post(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
      n = 0;
      while (!(m_busy && cyc == m_acc_cyc + 1) && n < 50) begin tick(); n++; end
      check("reach EXEC", (n < 50), 1);
      #1 rst = 1'b1;
      #1;
      check("exec rst rsp_valid", rsp_valid, 0);
      check("exec rst alu_a", alu_a, 0);
      check("exec rst alu_opcode", alu_opcode, 0);
      tick();
      tick();
      rst = 1'b0;

      // Reset during RESP
      n = 0;
      while (!(m_busy && cyc == m_acc_cyc + 3) && n < 50) begin tick(); n++; end
      check("reach RESP", (n < 50), 1);
      check("resp before reset", rsp_valid, 1);
      #1 rst = 1'b1;
      #1;
      check("resp rst rsp_valid", rsp_valid, 0);
      check("resp rst rsp_result", rsp_result, 0);
      check("resp rst rsp_id", rsp_id, 0);
      check("resp rst req_ready", req_ready, 0);
      for (int i = 0; i < N; i++) if (!req_valid[i]) post(i, $urandom, $urandom, OP_XOR);
      tick();
      tick();
      clear_logs();
      rst = 1'b0;
      drain("after mid-op reset");
      check("post-reset accept count", dut_acc_id.size(), 4);
      if (dut_acc_id.size() > 0) check("post-reset first grant", dut_acc_id[0], 0);

      // Randomized traffic with random back-pressure
      for (int c = 0; c < 600; c++) begin
         tick();
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               post(i, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
         end
      end
      rsp_ready = 1'b1;
      drain("random traffic");
      check("scoreboard empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
